spw_rx_fifo_credit: RTL

Receive buffer and flow-control credit manager that sits directly downstream of the SpaceWire receiver decoder. It stores every N-char written by the receiver (9-bit data/flag word: 8-bit data, or 9'd256 = EOP, 9'd257 = EEP) in a 64-entry FIFO. It tracks the credit granted to the remote end and requests FCT transmission from the transmitter whenever eight more characters of buffer space are available. It flags credit violations to the link FSM as the ECSS-E-ST-50-12C credit error.

---
 rtl/spw_rx_fifo_credit.sv | 98 +++++++++
 1 files changed

// File: rtl/spw_rx_fifo_credit.sv
// SpaceWire receive buffer (2^AWIDTH x DATA_WIDTH) with FCT credit accounting; registered read, 1-cycle latency.
// No backpressure to the decoder: writes without credit or into a full buffer are dropped and flagged sticky.
module spw_rx_fifo_credit #(
   parameter int DATA_WIDTH = 9,
   parameter int AWIDTH     = 6
) (
   input  logic                  pclk,
   input  logic                  resetn,
   input  logic                  link_running,
   input  logic                  rx_buffer_write,
   input  logic [DATA_WIDTH-1:0] rx_data_flag,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic                  empty,
   output logic                  full,
   output logic [AWIDTH:0]       counter_fifo,
   output logic [AWIDTH:0]       credit_outstanding,
   output logic                  fct_req,
   input  logic                  fct_sent,
   output logic                  rx_credit_error
);

   localparam int              DEPTH       = 1 << AWIDTH;
   localparam logic [AWIDTH:0] DEPTH_W     = DEPTH[AWIDTH:0];
   localparam logic [AWIDTH:0] CREDIT_MAX  = DEPTH_W - 16;
   localparam logic [AWIDTH:0] FCT_CREDIT  = 8;
   localparam logic [AWIDTH:0] ONE_W       = 1;
   localparam logic [AWIDTH+1:0] SUM_LIMIT = {1'b0, DEPTH_W};

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AWIDTH-1:0]     wr_ptr;
   logic [AWIDTH-1:0]     rd_ptr;
   logic                  wr_acc;
   logic                  wr_err;
   logic                  rd_acc;
   logic                  fct_acc;
   logic [AWIDTH+1:0]     space_sum;

   assign empty = (counter_fifo == '0);
   assign full  = (counter_fifo == DEPTH_W);

   // One extra bit on the sum so counter + credit + 8 can never wrap.
   assign space_sum = {1'b0, counter_fifo} + {1'b0, credit_outstanding} + {1'b0, FCT_CREDIT};
   assign fct_req  = link_running && (space_sum <= SUM_LIMIT) && (credit_outstanding <= CREDIT_MAX);

   assign wr_acc  = rx_buffer_write && link_running && (credit_outstanding != '0) && !full;
   assign wr_err  = rx_buffer_write && link_running && !wr_acc;
   assign rd_acc  = rd_en && link_running && !empty;
   assign fct_acc = fct_sent && fct_req;

   always_ff @(posedge pclk) begin
      if (wr_acc) begin
         mem[wr_ptr] <= rx_data_flag;
      end
   end

   always_ff @(posedge pclk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr             <= '0;
         rd_ptr             <= '0;
         counter_fifo       <= '0;
         credit_outstanding <= '0;
         rx_credit_error    <= 1'b0;
         rd_data            <= '0;
         rd_valid           <= 1'b0;
      end else if (!link_running) begin
         // Flush: buffered words are abandoned, rd_data keeps its last value.
         wr_ptr             <= '0;
         rd_ptr             <= '0;
         counter_fifo       <= '0;
         credit_outstanding <= '0;
         rx_credit_error    <= 1'b0;
         rd_valid           <= 1'b0;
      end else begin
         rd_valid <= rd_acc;
         if (wr_acc) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd_acc) begin
            rd_ptr  <= rd_ptr + 1'b1;
            rd_data <= mem[rd_ptr];
         end
         case ({wr_acc, rd_acc})
            2'b10:   counter_fifo <= counter_fifo + ONE_W;
            2'b01:   counter_fifo <= counter_fifo - ONE_W;
            default: counter_fifo <= counter_fifo;
         endcase
         credit_outstanding <= credit_outstanding
                               + (fct_acc ? FCT_CREDIT : '0)
                               - (wr_acc ? ONE_W : '0);
         if (wr_err) begin
            rx_credit_error <= 1'b1;
         end
      end
   end

endmodule
